// File: rtl/ucode_pkg.sv
// Shared types and helpers for the microcode sequencer family:
// state encoding and descriptor-table slicing.
package ucode_pkg;

  // Sequencer control states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Each descriptor table packs one ADDR_W field per program, program 0 in the LSBs
  function automatic int desc_lsb(input int idx, input int field_w);
    return idx * field_w;
  endfunction

endpackage

// File: rtl/ucode_out_stage.sv
// Single-entry valid/ready output register with synchronous flush.
// Accepts a new word whenever it is empty or being drained this cycle.
module ucode_out_stage #(
  parameter int W = 62
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Next-state: flush empties, load replaces, a drain without load empties
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Parametrised microcode sequencer: looks up a program's offset/length from
// the descriptor tables, walks an external combinational ROM and emits one
// registered micro-op per cycle over a valid/ready channel.
// Optional macro UCODE_REPEAT_EN adds start_repeat (extra passes per program).
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int NPROG   = 16,
  parameter int PROG_W  = 4,
  parameter int ADDR_W  = 5,
  parameter int UWORD_W = 56,
  parameter int REP_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [PROG_W-1:0]       start_prog,
`ifdef UCODE_REPEAT_EN
  input  logic [REP_W-1:0]        start_repeat,
`endif
  input  logic [NPROG*ADDR_W-1:0] prog_offset_tbl,
  input  logic [NPROG*ADDR_W-1:0] prog_length_tbl,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [UWORD_W-1:0]      rom_data,
  input  logic                    flush,
  output logic                    uop_valid,
  input  logic                    uop_ready,
  output logic [UWORD_W-1:0]      uop_word,
  output logic                    uop_last,
  output logic [ADDR_W-1:0]       uop_index,
  output logic                    done,
  output logic                    bad_prog,
  output logic                    busy
);

  localparam int OUT_W = UWORD_W + ADDR_W + 1;
  localparam logic [PROG_W:0] NPROG_C = (PROG_W + 1)'(NPROG);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] length_q, length_d;
  logic              done_q, done_d;
  logic              bad_q, bad_d;
  logic [ADDR_W-1:0] sel_offset, sel_length;
  logic              prog_bad, accept, load, last_step, final_pass;
  logic              stage_ready;
  logic [OUT_W-1:0]  stage_in, stage_out;

`ifdef UCODE_REPEAT_EN
  logic [REP_W-1:0]  rep_q, rep_d;
  assign final_pass = (rep_q == '0);
`else
  assign final_pass = 1'b1;
`endif

  assign prog_bad    = {1'b0, start_prog} >= NPROG_C;
  assign start_ready = (state_q == IDLE) & ~flush;
  assign accept      = start_valid & start_ready;
  assign rom_addr    = offset_q + count_q;
  assign last_step   = (count_q == length_q);
  assign load        = (state_q == RUN) & stage_ready & ~flush;
  assign stage_in    = {rom_data, count_q, last_step & final_pass};

  assign uop_word  = stage_out[OUT_W-1 -: UWORD_W];
  assign uop_index = stage_out[ADDR_W:1];
  assign uop_last  = stage_out[0];
  assign done      = done_q;
  assign bad_prog  = bad_q;
  assign busy      = (state_q == RUN) | uop_valid;

  // Descriptor lookup; out-of-range programs select zero and are rejected anyway
  always_comb begin
    sel_offset = '0;
    sel_length = '0;
    for (int i = 0; i < NPROG; i++) begin
      if (start_prog == PROG_W'(i)) begin
        sel_offset = prog_offset_tbl[desc_lsb(i, ADDR_W) +: ADDR_W];
        sel_length = prog_length_tbl[desc_lsb(i, ADDR_W) +: ADDR_W];
      end
    end
  end

  // Control FSM next-state: flush dominates, then accept (IDLE) or step (RUN)
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    offset_d = offset_q;
    length_d = length_q;
`ifdef UCODE_REPEAT_EN
    rep_d    = rep_q;
`endif
    bad_d    = accept & prog_bad;
    done_d   = uop_valid & uop_ready & uop_last & ~flush;
    if (flush) begin
      state_d = IDLE;
      count_d = '0;
`ifdef UCODE_REPEAT_EN
      rep_d   = '0;
`endif
    end else if (accept) begin
      if (!prog_bad) begin
        state_d  = RUN;
        count_d  = '0;
        offset_d = sel_offset;
        length_d = sel_length;
`ifdef UCODE_REPEAT_EN
        rep_d    = start_repeat;
`endif
      end
    end else if (load) begin
      count_d = count_q + 1'b1;
      if (last_step) begin
`ifdef UCODE_REPEAT_EN
        if (rep_q != '0) begin
          rep_d   = rep_q - 1'b1;
          count_d = '0;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
    end
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      offset_q <= '0;
      length_q <= '0;
      done_q   <= 1'b0;
      bad_q    <= 1'b0;
`ifdef UCODE_REPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      offset_q <= offset_d;
      length_q <= length_d;
      done_q   <= done_d;
      bad_q    <= bad_d;
`ifdef UCODE_REPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  ucode_out_stage #(
    .W (OUT_W)
  ) u_out_stage (
    .clk         (clk),
    .rst_ni      (reset),
    .flush_i     (flush),
    .in_valid_i  (load),
    .in_ready_o  (stage_ready),
    .in_data_i   (stage_in),
    .out_valid_o (uop_valid),
    .out_ready_i (uop_ready),
    .out_data_o  (stage_out)
  );

endmodule
